// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter and its response router.
// Port index/select types and the one-hot encode/decode helpers live here.
package arb_pkg;

  localparam int NPORT = 4;

  typedef logic [1:0] port_idx_t;
  typedef logic [3:0] port_sel_t;

  // Lowest set bit wins, so a malformed multi-hot select still maps to a legal port.
  function automatic port_idx_t sel2idx(input port_sel_t sel);
    port_idx_t idx;
    idx = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      if (sel[i]) idx = port_idx_t'(i);
    end
    return idx;
  endfunction

  function automatic port_sel_t idx2sel(input port_idx_t idx);
    return port_sel_t'(1) << idx;
  endfunction

  function automatic logic is_onehot(input port_sel_t sel);
    return (sel != '0) && ((sel & (sel - port_sel_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/resp_router_if.sv
// Push/response bundle between the arbiter, the shared response bus and resp_router.
// The router side uses the slave modport; the driving side uses master.
interface resp_router_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 64
);
  import arb_pkg::*;

  port_sel_t                SEL;
  logic                     NEXT;
  logic                     RVALID;
  logic [DW-1:0]            RDATA;
  logic                     STALL;
  port_sel_t                OVALID;
  logic [DW-1:0]            ODATA;
  logic [$clog2(DEPTH):0]   PENDING;
  logic                     ERR;

  modport master (
    output SEL, NEXT, RVALID, RDATA,
    input  STALL, OVALID, ODATA, PENDING, ERR
  );

  modport slave (
    input  SEL, NEXT, RVALID, RDATA,
    output STALL, OVALID, ODATA, PENDING, ERR
  );

endinterface

// File: rtl/resp_router_tag_fifo.sv
// tag_fifo: in-order store of the port index for each outstanding request.
// A push while full is accepted only if a pop frees the slot in the same cycle.
module tag_fifo
  import arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   i_push,
  input  port_idx_t              i_tag,
  input  logic                   i_pop,
  output port_idx_t              o_tag,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  port_idx_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            w_push_ok;
  logic            w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_comb begin
    // NOTE: default assignment first so no path leaves w_count_nxt unassigned (no latch).
    w_count_nxt = r_count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_tag;
  end

  assign o_tag   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/resp_router.sv
// resp_router: records each arbiter grant and steers in-order responses back to it.
// Define RESP_ROUTER_CHECK_EN to enable the sticky ERR protocol checker.
module resp_router
  import arb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = 64
) (
  input logic          CLK,
  input logic          RESET,
  resp_router_if.slave bus
);

  port_sel_t              w_sel;
  logic                   w_sel_any;
  logic                   w_push_req;
  logic                   w_pop_ok;
  logic                   w_full;
  logic                   w_empty;
  port_idx_t              w_pop_idx;
  logic [$clog2(DEPTH):0] w_count;
  port_sel_t              r_ovalid;
  logic [DW-1:0]          r_odata;

  assign w_sel     = bus.SEL;
  assign w_sel_any = |w_sel;
  assign w_pop_ok  = bus.RVALID & ~w_empty;

  tag_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push_req),
    .i_tag   (sel2idx(w_sel)),
    .i_pop   (bus.RVALID),
    .o_tag   (w_pop_idx),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Responses with no matching tag are dropped: OVALID stays low, ODATA holds.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ovalid <= '0;
      r_odata  <= '0;
    end else begin
      r_ovalid <= w_pop_ok ? idx2sel(w_pop_idx) : '0;
      if (w_pop_ok) r_odata <= bus.RDATA;
    end
  end

`ifdef RESP_ROUTER_CHECK_EN
  logic w_sel_bad;
  logic w_overflow;
  logic w_underflow;
  logic r_err;

  // A multi-hot grant is an arbiter fault; the push is refused rather than guessed.
  assign w_sel_bad   = bus.NEXT & w_sel_any & ~is_onehot(w_sel);
  assign w_push_req  = bus.NEXT & is_onehot(w_sel);
  assign w_overflow  = w_push_req & w_full & ~w_pop_ok;
  assign w_underflow = bus.RVALID & w_empty;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_err <= 1'b0;
    else        r_err <= r_err | w_sel_bad | w_overflow | w_underflow;
  end

  assign bus.ERR = r_err;
`else
  assign w_push_req = bus.NEXT & w_sel_any;
  assign bus.ERR    = 1'b0;
`endif

  assign bus.STALL   = w_full;
  assign bus.PENDING = w_count;
  assign bus.OVALID  = r_ovalid;
  assign bus.ODATA   = r_odata;

endmodule
